// File: rtl/edge_pkg.sv
// Shared constants, FSM state type and popcount helper for the ROM edge scanner.
package edge_pkg;

  localparam int unsigned ROW_W    = 64;
  localparam int unsigned NUM_ROWS = 48;
  localparam int unsigned ADDR_W   = 6;
  localparam int unsigned CNT_W    = 12;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  function automatic logic [6:0] popcount(input logic [ROW_W-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < ROW_W; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/edge_row_calc.sv
// Combinational edge map of one image row against the previous row, plus its pixel count.
module edge_row_calc
  import edge_pkg::*;
(
  input  logic [ROW_W-1:0] cur_row,
  input  logic [ROW_W-1:0] prev_row,
  output logic [ROW_W-1:0] edge_bits,
  output logic [6:0]       pop
);

  logic [ROW_W-1:0] h_edge;
  logic [ROW_W-1:0] v_edge;

  always_comb begin
    // Right shift pulls each pixel's left neighbour into place; a zero enters at the border.
    h_edge    = cur_row ^ (cur_row >> 1);
    v_edge    = cur_row ^ prev_row;
    edge_bits = h_edge | v_edge;
    pop       = popcount(edge_bits);
  end

endmodule

// File: rtl/rom_edge_scanner.sv
// Walks the image ROM once per start, streams per-row edge maps out and totals edge pixels.
module rom_edge_scanner
  import edge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROW_W-1:0]  rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_row,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  edge_count
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

  state_t            state;
  logic [ADDR_W-1:0] row_cnt;
  logic [ROW_W-1:0]  prev_row;
  logic [ROW_W-1:0]  edge_bits;
  logic [6:0]        pop;

  edge_row_calc u_calc (
    .cur_row   (rom_data),
    .prev_row  (prev_row),
    .edge_bits (edge_bits),
    .pop       (pop)
  );

  assign rom_addr = row_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row_cnt    <= '0;
      prev_row   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      edge_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= SCAN;
            row_cnt    <= '0;
            prev_row   <= '0;
            edge_count <= '0;
            busy       <= 1'b1;
          end
        end
        SCAN: begin
          // Output slot is free when empty or being drained this very cycle.
          if (!out_valid || out_ready) begin
            out_data   <= edge_bits;
            out_row    <= row_cnt;
            out_valid  <= 1'b1;
            prev_row   <= rom_data;
            edge_count <= edge_count + CNT_W'(pop);
            row_cnt    <= row_cnt + 1'b1;
            if (row_cnt == LAST_ROW) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_edge_scanner.sv
// Directed bench for rom_edge_scanner: full-throughput frame, random back-pressure, reset abort.
module tb_rom_edge_scanner;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  rom_addr;
  logic [63:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [5:0]  out_row;
  logic        busy;
  logic        done;
  logic [11:0] edge_count;

  int          n_checks;
  int          n_fail;
  logic [11:0] exp_total;

  rom_edge_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .busy       (busy),
    .done       (done),
    .edge_count (edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image stand-in: rows 29..46 hold 0x7 and row 47 holds 0x7F.
  function automatic logic [63:0] rom_row(input logic [5:0] a);
    if (a < 6'd10)      return 64'h0;
    else if (a < 6'd20) return 64'hFF00_0000_0000_00F0;
    else if (a < 6'd25) return 64'h0000_FFFF_0000_0000 | {58'h0, a};
    else if (a < 6'd29) return 64'hAAAA_0000_5555_0000;
    else if (a < 6'd47) return 64'h7;
    else if (a == 6'd47) return 64'h7F;
    else return 64'h0;
  endfunction

  always_comb rom_data = rom_row(rom_addr);

  function automatic logic [63:0] model_edge(input int r);
    logic [63:0] row;
    logic [63:0] prev;
    logic [63:0] e;
    logic        left;
    row  = rom_row(6'(r));
    prev = (r == 0) ? 64'h0 : rom_row(6'(r - 1));
    for (int i = 0; i < 64; i++) begin
      left = (i == 63) ? 1'b0 : row[i+1];
      e[i] = (row[i] ^ left) | (row[i] ^ prev[i]);
    end
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero();
    check_eq("rst_rom_addr", 64'(rom_addr), 64'h0);
    check_eq("rst_out_valid", 64'(out_valid), 64'h0);
    check_eq("rst_out_data", out_data, 64'h0);
    check_eq("rst_out_row", 64'(out_row), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_done", 64'(done), 64'h0);
    check_eq("rst_edge_count", 64'(edge_count), 64'h0);
  endtask

  // Entered from IDLE, #1 after an edge; start is sampled at the next edge (cycle T).
  task automatic run_clean_frame();
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t1_busy", 64'(busy), 64'h1);
    check_eq("t1_out_valid", 64'(out_valid), 64'h0);
    tick();
    for (int r = 0; r < 48; r++) begin
      check_eq("seq_valid", 64'(out_valid), 64'h1);
      check_eq("seq_row", 64'(out_row), 64'(r));
      check_eq("seq_data", out_data, model_edge(r));
      check_eq("seq_done_low", 64'(done), 64'h0);
      if (r == 30) check_eq("row30_data", out_data, 64'h0000_0000_0000_0004);
      if (r == 47) check_eq("row47_data", out_data, 64'h0000_0000_0000_0078);
      tick();
    end
    check_eq("t50_done", 64'(done), 64'h1);
    check_eq("t50_busy", 64'(busy), 64'h1);
    check_eq("t50_valid", 64'(out_valid), 64'h0);
    check_eq("t50_count", 64'(edge_count), 64'(exp_total));
    tick();
    check_eq("t51_done", 64'(done), 64'h0);
    check_eq("t51_busy", 64'(busy), 64'h0);
    check_eq("t51_count", 64'(edge_count), 64'(exp_total));
  endtask

  task automatic run_random_frame();
    int          exp_row;
    int          cycles;
    int          post;
    int          done_cnt;
    logic        prev_stall;
    logic        rdy;
    logic [63:0] held_data;
    logic [5:0]  held_row;
    exp_row    = 0;
    cycles     = 0;
    post       = 0;
    done_cnt   = 0;
    prev_stall = 1'b0;
    held_data  = '0;
    held_row   = '0;
    out_ready  = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    while (cycles < 1000 && post < 20) begin
      cycles++;
      if (done_cnt > 0) post++;
      if (prev_stall) begin
        check_eq("stall_row", 64'(out_row), 64'(held_row));
        check_eq("stall_data", out_data, held_data);
      end
      if (done) done_cnt++;
      start = (cycles == 10);
      rdy = (($urandom % 3) != 0);
      out_ready = rdy;
      if (out_valid && rdy) begin
        check_eq("rnd_row", 64'(out_row), 64'(exp_row));
        check_eq("rnd_data", out_data, model_edge(exp_row));
        exp_row++;
      end
      prev_stall = out_valid && !rdy;
      held_data  = out_data;
      held_row   = out_row;
      tick();
    end
    start = 1'b0;
    check_eq("rnd_finished", 64'(post >= 20), 64'h1);
    check_eq("rnd_rows_xfer", 64'(exp_row), 64'd48);
    check_eq("rnd_done_pulses", 64'(done_cnt), 64'd1);
    check_eq("rnd_count", 64'(edge_count), 64'(exp_total));
  endtask

  task automatic run_reset_abort();
    int   waited;
    logic seen;
    logic activity;
    waited    = 0;
    seen      = 1'b0;
    activity  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    while (!seen && waited < 40) begin
      if (out_valid && out_row == 6'd20) seen = 1'b1;
      else begin
        waited++;
        tick();
      end
    end
    check_eq("abort_reached_row20", 64'(seen), 64'h1);
    rst = 1'b1;
    tick();
    check_all_zero();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      activity = activity | done | busy | out_valid;
    end
    check_eq("abort_quiet", 64'(activity), 64'h0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_total = '0;
    for (int r = 0; r < 48; r++) begin
      logic [63:0] e;
      e = model_edge(r);
      for (int i = 0; i < 64; i++) exp_total = exp_total + 12'(e[i]);
    end

    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_all_zero();
    rst = 1'b0;
    tick();

    run_clean_frame();
    tick();
    run_random_frame();
    tick();
    run_reset_abort();
    run_clean_frame();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_edge_scanner.md
Name: rom_edge_scanner

Overview:
- Downstream consumer of the 64x48 binary image ROM (6-bit address, 64-bit row, combinational read) in the edgeDetector design.
- On `start`, walks ROM rows 0..NUM_ROWS-1 and computes a per-row edge map: horizontal transitions within a row OR vertical transitions against the previous row.
- Streams edge rows out over a valid/ready handshake and accumulates a total edge-pixel count.

Parameters:
- ROW_W, 64, pixels per row (ROM data width)
- NUM_ROWS, 48, rows scanned per frame (ROM addresses 0..47)
- ADDR_W, 6, ROM address width
- CNT_W, 12, edge counter width (ceil log2(ROW_W*NUM_ROWS+1))

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame scan; sampled only in IDLE
- rom_addr  out  ADDR_W  address driven to ROM
- rom_data  in  ROW_W  ROM row, valid the same cycle as rom_addr
- out_valid  out  1  edge row available
- out_ready  in  1  consumer accepts edge row
- out_data  out  ROW_W  edge map for row out_row
- out_row  out  ADDR_W  row index of out_data
- busy  out  1  high from the cycle after start through the done cycle
- done  out  1  one-cycle pulse after the last row handshake
- edge_count  out  CNT_W  total edge pixels of the current/last frame

Behaviour:
- Reset values: rom_addr=0, out_valid=0, out_data=0, out_row=0, busy=0, done=0, edge_count=0, prev_row=0, state=IDLE. Reset mid-scan aborts immediately; no further output and no done pulse.
- FSM states:
  - IDLE: start=1 -> SCAN; row_cnt=0, prev_row=0, edge_count=0.
  - SCAN: runs until the last row is loaded into the output register.
  - DRAIN: waits for the handshake of the last row -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start is ignored outside IDLE.
- rom_addr = row_cnt. It is registered, so it is stable during the cycle rom_data is used.
- Edge function for row r, pixel i (bit 63 = leftmost):
  - h[i] = row[i] ^ row[i+1], with row[64] = 0 (border is background).
  - v[i] = row[i] ^ prev_row[i]; prev_row = 0 for row 0.
  - edge[i] = h[i] | v[i].
- Load rule: in SCAN, when (!out_valid || out_ready), register out_data=edge, out_row=row_cnt, out_valid=1, prev_row=rom_data, edge_count += popcount(edge) (7-bit popcount zero-extended), then row_cnt++.
- Handshake: a transfer occurs on a cycle with out_valid && out_ready. While out_valid && !out_ready, out_data and out_row hold and row_cnt does not advance. out_valid drops after the handshake only if no new row is loaded in the same cycle.
- Latency: start seen in cycle T. First out_valid is at T+2. With out_ready held high, one row per cycle follows. Last row (47) is valid at T+49 and handshakes that cycle; done=1 at T+50; busy falls at T+51.
- edge_count holds its value from done until the next start clears it. The counter cannot overflow (3072 < 4096).
- Simultaneous load and handshake in the same cycle is legal and gives full throughput.

Decomposition:
- Package `edge_pkg`: ROW_W, NUM_ROWS, ADDR_W, CNT_W, `state_t` enum {IDLE, SCAN, DRAIN, DONE}, and the popcount function.
- Sub-module `edge_row_calc` (combinational): inputs cur_row and prev_row; outputs edge[ROW_W-1:0] and pop[6:0].
- The scanner instantiates `edge_row_calc` and connects to the existing `rom` instance at top level.

Test Plan:
- Reset then start with out_ready=1 -> out_row sequence 0..47 on consecutive cycles from T+2, done pulse at T+50, busy low at T+51.
- Row 30 (ROM 0x7, prev 0x7) -> out_data = 64'h0000_0000_0000_0004. Row 47 (ROM 0x7F, prev 0x7) -> out_data = 64'h0000_0000_0000_0078.
- out_ready toggled pseudo-randomly -> out_data and out_row stable while stalled; no row dropped or duplicated. edge_count matches a reference-model sum over all 48 rows, identical to the ready-always-high run.
- start pulsed during SCAN -> ignored; scan completes normally with exactly one done pulse.
- rst asserted at row 20 -> next cycle all outputs are zero and state is IDLE. A new start produces a full frame from row 0 with the same edge_count as a clean run.
